// File: rtl/yarv_pkg.sv
// Shared decode definitions: instruction classes, RV32I opcodes, bubble word.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package yarv_pkg;

   typedef enum logic [3:0] {
      CLS_NONE   = 4'd0,
      CLS_LUI    = 4'd1,
      CLS_AUIPC  = 4'd2,
      CLS_JAL    = 4'd3,
      CLS_JALR   = 4'd4,
      CLS_BRANCH = 4'd5,
      CLS_LOAD   = 4'd6,
      CLS_STORE  = 4'd7,
      CLS_OPIMM  = 4'd8,
      CLS_OP     = 4'd9,
      CLS_FENCE  = 4'd10,
      CLS_SYSTEM = 4'd11
   } class_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // Fetch presents this word out of reset; it never reaches execute.
   localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

   // Opcode to class; anything unrecognised maps to CLS_NONE.
   function automatic class_t opcode_class(input logic [6:0] opc);
      class_t c;
      case (opc)
         OPC_LUI:    c = CLS_LUI;
         OPC_AUIPC:  c = CLS_AUIPC;
         OPC_JAL:    c = CLS_JAL;
         OPC_JALR:   c = CLS_JALR;
         OPC_BRANCH: c = CLS_BRANCH;
         OPC_LOAD:   c = CLS_LOAD;
         OPC_STORE:  c = CLS_STORE;
         OPC_OPIMM:  c = CLS_OPIMM;
         OPC_OP:     c = CLS_OP;
         OPC_FENCE:  c = CLS_FENCE;
         OPC_SYSTEM: c = CLS_SYSTEM;
         default:    c = CLS_NONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: builds the sign-extended 32-bit immediate for a class.
// Latency: purely combinational.
// Backpressure: none (no state).
import yarv_pkg::*;

module imm_gen (
   input  logic [31:7] instr,
   input  logic [3:0]  cls,
   output logic [31:0] imm
);

   // Select the immediate format by class; classes without one produce 0.
   always_comb begin
      imm = 32'h0;
      case (cls)
         CLS_JALR, CLS_LOAD, CLS_OPIMM, CLS_SYSTEM:
            imm = {{20{instr[31]}}, instr[31:20]};
         CLS_STORE:
            imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         CLS_BRANCH:
            imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         CLS_LUI, CLS_AUIPC:
            imm = {instr[31:12], 12'h000};
         CLS_JAL:
            imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default:
            imm = 32'h0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: fetch word/PC -> class, operands, immediate; owns load-use stall. Option: DECODE_ILLEGAL_EN.
// Latency: one cycle to the decode register; stall_out is combinational.
// Backpressure: hlt freezes the register, flush squashes it, a load-use hazard inserts one bubble.
import yarv_pkg::*;

module decode_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hlt,
   input  logic        flush,
   input  logic [31:0] instruction,
   input  logic [31:0] inpc,
   output logic        stall_out,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [3:0]  out_class,
   output logic [4:0]  out_rd,
   output logic [4:0]  out_rs1,
   output logic [4:0]  out_rs2,
   output logic [31:0] out_imm,
   output logic [2:0]  out_funct3,
`ifdef DECODE_ILLEGAL_EN
   output logic        out_illegal,
`endif
   output logic        out_funct7b5
);

   // Combinational decode of the incoming word
   logic        dec_valid;
   class_t      dec_class;
   logic [4:0]  dec_rd;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic [31:0] dec_imm;
   logic        dec_illegal;
   logic        load_use;

   // Decode register
   logic        reg_valid;
   class_t      reg_class;
   logic [31:0] reg_pc;
   logic [4:0]  reg_rd;
   logic [4:0]  reg_rs1;
   logic [4:0]  reg_rs2;
   logic [31:0] reg_imm;
   logic [2:0]  reg_funct3;
   logic        reg_funct7b5;
   logic        reg_illegal;

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;

   assign opc = instruction[6:0];
   assign f3  = instruction[14:12];
   assign f7  = instruction[31:25];

   // Classify the word and force unused register fields to zero.
   always_comb begin
      class_t raw_class;
      dec_valid   = (instruction != BUBBLE_INSTR);
      raw_class   = dec_valid ? opcode_class(opc) : CLS_NONE;
      dec_illegal = 1'b0;
`ifdef DECODE_ILLEGAL_EN
      if (dec_valid) begin
         if (instruction[1:0] != 2'b11 || raw_class == CLS_NONE) begin
            dec_illegal = 1'b1;
         end else begin
            case (raw_class)
               CLS_OP:
                  dec_illegal = !(f7 == 7'b0000000 ||
                                 (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
               CLS_OPIMM:
                  dec_illegal = (f3 == 3'b001 && f7 != 7'b0000000) ||
                                (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000);
               CLS_BRANCH:
                  dec_illegal = (f3 == 3'b010 || f3 == 3'b011);
               CLS_LOAD:
                  dec_illegal = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
               CLS_STORE:
                  dec_illegal = (f3[2] || f3 == 3'b011);
               default:
                  dec_illegal = 1'b0;
            endcase
         end
      end
`endif
      dec_class = dec_illegal ? CLS_NONE : raw_class;

      dec_rd = instruction[11:7];
      if (dec_class == CLS_NONE || dec_class == CLS_BRANCH ||
          dec_class == CLS_STORE || dec_class == CLS_FENCE) begin
         dec_rd = 5'd0;
      end

      dec_rs1 = instruction[19:15];
      if (dec_class == CLS_LUI || dec_class == CLS_AUIPC || dec_class == CLS_JAL) begin
         dec_rs1 = 5'd0;
      end

      dec_rs2 = 5'd0;
      if (dec_class == CLS_BRANCH || dec_class == CLS_STORE || dec_class == CLS_OP) begin
         dec_rs2 = instruction[24:20];
      end
   end

   imm_gen u_imm_gen (
      .instr (instruction[31:7]),
      .cls   (dec_class),
      .imm   (dec_imm)
   );

   // A load sitting in the register whose result the incoming word reads.
   always_comb begin
      load_use = reg_valid && (reg_class == CLS_LOAD) && (reg_rd != 5'd0) &&
                 ((dec_rs1 == reg_rd) || (dec_rs2 == reg_rd));
   end

   assign stall_out = hlt | load_use;

   // Decode register: flush beats hlt, hlt beats the load-use bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_valid    <= 1'b0;
         reg_class    <= CLS_NONE;
         reg_pc       <= RESET_PC;
         reg_rd       <= 5'd0;
         reg_rs1      <= 5'd0;
         reg_rs2      <= 5'd0;
         reg_imm      <= 32'h0;
         reg_funct3   <= 3'd0;
         reg_funct7b5 <= 1'b0;
         reg_illegal  <= 1'b0;
      end else if (flush || (!hlt && load_use)) begin
         reg_valid    <= 1'b0;
         reg_class    <= CLS_NONE;
         reg_pc       <= RESET_PC;
         reg_rd       <= 5'd0;
         reg_rs1      <= 5'd0;
         reg_rs2      <= 5'd0;
         reg_imm      <= 32'h0;
         reg_funct3   <= 3'd0;
         reg_funct7b5 <= 1'b0;
         reg_illegal  <= 1'b0;
      end else if (!hlt) begin
         reg_valid    <= dec_valid;
         reg_class    <= dec_class;
         reg_pc       <= dec_valid ? inpc : RESET_PC;
         reg_rd       <= dec_rd;
         reg_rs1      <= dec_rs1;
         reg_rs2      <= dec_rs2;
         reg_imm      <= dec_imm;
         reg_funct3   <= f3;
         reg_funct7b5 <= instruction[30];
         reg_illegal  <= dec_illegal;
      end
   end

   assign out_valid    = reg_valid;
   assign out_class    = reg_class;
   assign out_pc       = reg_pc;
   assign out_rd       = reg_rd;
   assign out_rs1      = reg_rs1;
   assign out_rs2      = reg_rs2;
   assign out_imm      = reg_imm;
   assign out_funct3   = reg_funct3;
   assign out_funct7b5 = reg_funct7b5;
`ifdef DECODE_ILLEGAL_EN
   assign out_illegal  = reg_illegal;
`else
   logic unused_illegal;
   assign unused_illegal = reg_illegal | dec_illegal;
`endif

endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage of the core. Takes the registered instruction word and PC produced by the fetch stage and decodes them into operand indices, a sign-extended immediate and an instruction class, held in a pipeline register for the execute stage. Owns load-use hazard detection and drives the stall back into fetch. Also honours downstream stall and branch-flush requests.

## Interface
- RESET_PC, 32'h00000000: value of `out_pc` after reset and in bubbles.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- hlt  in  1  downstream stall; freeze the decode register.
- flush  in  1  branch redirect from execute; squash the decode register.
- instruction  in  32  instruction word from fetch.
- inpc  in  32  PC of `instruction`.
- stall_out  out  1  hold request to fetch (drives fetch `hlt`).
- out_valid  out  1  decode register holds a real instruction.
- out_pc  out  32  PC of the decoded instruction.
- out_class  out  4  instruction class enum.
- out_rd, out_rs1, out_rs2  out  5 each  register indices.
- out_imm  out  32  sign-extended immediate.
- out_funct3  out  3  instr[14:12].
- out_funct7b5  out  1  instr[30].
- out_illegal  out  1  only with `DECODE_ILLEGAL_EN`.

## Operation
- Classes: NONE=0, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, FENCE, SYSTEM. Selection is by opcode instr[6:0].
- Instruction word 32'h00000000 (fetch reset value) decodes as a bubble: out_valid=0, class NONE.
- Immediates by class:
  - I for JALR/LOAD/OPIMM/SYSTEM.
  - S for STORE.
  - B for BRANCH.
  - U for LUI/AUIPC.
  - J for JAL.
  - 0 otherwise.
  - All 32-bit, sign bit instr[31]; B/J have LSB 0.
- Unused register fields are forced to 0:
  - rd=0 for BRANCH/STORE/FENCE.
  - rs1=0 for LUI/AUIPC/JAL.
  - rs2=0 unless BRANCH/STORE/OP.
- Load-use hazard:
  - Condition: register holds out_valid=1 LOAD with out_rd≠0, and the incoming word's forced rs1 or rs2 equals out_rd.
  - Action: load_use=1.
- stall_out = hlt | load_use.
- Register update priority at each edge:
  - flush: load bubble (out_valid=0, class NONE, all fields 0, out_pc=RESET_PC).
  - else hlt: hold all outputs.
  - else load_use: load bubble.
  - else: load decoded instruction.
- flush masks load_use: stall_out still follows hlt | load_use, and controller timing handles the wrong-path word.

## Timing
- Reset (async assert, sync release):
  - out_valid=0, out_class=NONE, out_pc=RESET_PC.
  - rd/rs1/rs2/imm/funct3/funct7b5 all 0.
  - out_illegal=0.
- Latency: one cycle from instruction/inpc to out_*.
- stall_out is combinational from inputs and the decode register, with no register in that path.
- A load-use stall lasts exactly one cycle with hlt low:
  - The bubble enters the decode register.
  - Next cycle no hazard exists and the held instruction decodes.
- Reset asserted mid-stall clears everything; the first post-reset edge decodes the fetch reset word as a bubble.

## Configuration
- `DECODE_ILLEGAL_EN` defined:
  - out_illegal=1 with out_valid=1 for an unknown opcode, instr[1:0]≠2'b11, or invalid funct3/funct7 for OP/OPIMM shifts/BRANCH/LOAD/STORE.
  - class forced to NONE; rd forced to 0.
- Undefined: port out_illegal absent; unknown opcodes decode as valid class NONE with rd=0.

## Structure
- Shared package `yarv_pkg`: class enum, opcode constants (OPC_LUI=7'b0110111 …), and the bubble instruction value.
- One combinational sub-module `imm_gen` (instr, class → imm). The hazard logic and register stay in `decode_stage`.

## Test plan
- Reset: drive rst_n=0 with random inputs → all outputs at reset values, stall_out=hlt.
- ADDI x5,x1,-1 (32'hFFF08293), inpc=0x100 → next cycle valid, OPIMM, rd=5, rs1=1, rs2=0, imm=0xFFFFFFFF, out_pc=0x100.
- LW x3,0(x2) then ADD x4,x3,x1 held at input:
  - stall_out=1 for one cycle; bubble registered.
  - Next cycle ADD decoded, stall_out=0.
- LW x0 followed by a user of x0 → no stall.
- BEQ 32'hFE000EE3 with flush=1 and hlt=1 → bubble registered (flush wins). Without flush: class BRANCH, rd=0, imm=0xFFFFFFFC.
- hlt=1 for 3 cycles with changing input → outputs frozen, stall_out=1.
- With DECODE_ILLEGAL_EN, 32'hFFFFFFFF → out_illegal=1, out_valid=1, class NONE.
